// File: rtl/bcd_pkg.sv
// Shared types and constants for the packed-BCD counter family.
package bcd_pkg;

  localparam int N_DIGITS = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef logic [3:0]  bcd_digit_t;
  typedef logic [15:0] bcd4_t;
  typedef logic [1:0]  scan_idx_t;

  // Non-decimal nibbles collapse to zero so the stored count is always valid BCD.
  function automatic bcd_digit_t bcd_sanitize(input bcd_digit_t d);
    return (d > BCD_MAX) ? bcd_digit_t'(0) : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade cell of the BCD counter: holds one digit and ripples a carry or
// borrow to the next decade. Loads are sanitised here, one nibble per cell.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  bcd_digit_t load_val,
  input  logic       step_in,
  input  logic       up,
  output bcd_digit_t digit,
  output logic       step_out
);

  bcd_digit_t digit_q;
  bcd_digit_t digit_nxt;

  // Next-digit decode: load wins, otherwise step up or down with decade wrap.
  always_comb begin
    digit_nxt = digit_q;
    if (load) begin
      digit_nxt = bcd_sanitize(load_val);
    end else if (step_in) begin
      if (up) begin
        digit_nxt = (digit_q == BCD_MAX) ? bcd_digit_t'(0) : digit_q + 4'd1;
      end else begin
        digit_nxt = (digit_q == 4'd0) ? BCD_MAX : digit_q - 4'd1;
      end
    end
  end

  // Digit register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_nxt;
    end
  end

  // The upstream step is already suppressed during a load, so no load gating here.
  assign step_out = step_in & (up ? (digit_q == BCD_MAX) : (digit_q == 4'd0));
  assign digit    = digit_q;

endmodule

// File: rtl/bcd4_scan_counter.sv
// Four-digit packed-BCD up/down counter with a free-running digit scanner
// feeding a downstream BCD-to-7-segment decoder.
module bcd4_scan_counter
  import bcd_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iEn,
  input  logic        iUp,
  input  logic        iLoad,
  input  logic [15:0] iLoadVal,
  output logic [15:0] oCount,
  output logic        oCarry,
  output logic [3:0]  oBCD,
  output logic [3:0]  oDigitSel
);

  localparam logic [15:0] PRE_TC = 16'(SCAN_DIV - 1);

  bcd4_t               count;
  logic [N_DIGITS:0]   step_chain;
  logic                carry_q;
  logic [15:0]         pre_cnt;
  logic                pre_tc;
  scan_idx_t           scan_idx;

  // A load takes the whole cycle, so the step chain is only fed when not loading.
  assign step_chain[0] = iEn & ~iLoad;

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk      (iClk),
      .rst      (iRst),
      .load     (iLoad),
      .load_val (iLoadVal[4*g +: 4]),
      .step_in  (step_chain[g]),
      .up       (iUp),
      .digit    (count[4*g +: 4]),
      .step_out (step_chain[g+1])
    );
  end

  // Wrap pulse: the thousands step-out is exactly a 9999->0000 or 0000->9999 wrap.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      carry_q <= 1'b0;
    end else begin
      carry_q <= step_chain[N_DIGITS];
    end
  end

  assign pre_tc = (pre_cnt == PRE_TC);

  // Prescaler counts 0..SCAN_DIV-1, independent of counting and loading.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      pre_cnt <= '0;
    end else if (pre_tc) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 16'd1;
    end
  end

  // Scan index advances once per prescaler terminal count, wrapping 3->0.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      scan_idx <= '0;
    end else if (pre_tc) begin
      scan_idx <= scan_idx + 2'd1;
    end
  end

  // Digit select and BCD mux decode straight from registers so both move on the same edge.
  always_comb begin
    oDigitSel = 4'b0001;
    oBCD      = count[3:0];
    case (scan_idx)
      2'd0: begin oDigitSel = 4'b0001; oBCD = count[3:0];   end
      2'd1: begin oDigitSel = 4'b0010; oBCD = count[7:4];   end
      2'd2: begin oDigitSel = 4'b0100; oBCD = count[11:8];  end
      2'd3: begin oDigitSel = 4'b1000; oBCD = count[15:12]; end
      default: begin oDigitSel = 4'b0001; oBCD = count[3:0]; end
    endcase
  end

  assign oCount = count;
  assign oCarry = carry_q;

endmodule

// File: tb/tb_bcd4_scan_counter.sv
// Self-checking bench for bcd4_scan_counter with SCAN_DIV = 4.
module tb_bcd4_scan_counter;

  localparam int SD = 4;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic        iEn = 1'b0;
  logic        iUp = 1'b0;
  logic        iLoad = 1'b0;
  logic [15:0] iLoadVal = 16'h0000;
  logic [15:0] oCount;
  logic        oCarry;
  logic [3:0]  oBCD;
  logic [3:0]  oDigitSel;

  int checks = 0;
  int errors = 0;
  int edges  = 0;

  typedef struct {
    logic        load;
    logic [15:0] load_val;
    logic        en;
    logic        up;
    logic [15:0] exp_count;
    logic        exp_carry;
  } vec_t;

  vec_t vecs[$];

  bcd4_scan_counter #(.SCAN_DIV(SD)) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iEn       (iEn),
    .iUp       (iUp),
    .iLoad     (iLoad),
    .iLoadVal  (iLoadVal),
    .oCount    (oCount),
    .oCarry    (oCarry),
    .oBCD      (oBCD),
    .oDigitSel (oDigitSel)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge iClk);
    edges++;
    #1;
  endtask

  // Scanner model: after n edges from reset the index is (n / SD) mod 4.
  task automatic check_scan(input string name, input logic [15:0] cnt);
    int idx;
    logic [15:0] sh;
    logic [3:0] exp_sel;
    idx = (edges / SD) % 4;
    sh = cnt >> (4 * idx);
    exp_sel = 4'b0001 << idx;
    check({name, "_sel"}, {28'h0, oDigitSel}, {28'h0, exp_sel});
    check({name, "_bcd"}, {28'h0, oBCD}, {28'h0, sh[3:0]});
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_count"}, {16'h0, oCount}, 32'h0);
    check({name, "_carry"}, {31'h0, oCarry}, 32'h0);
    check({name, "_sel"}, {28'h0, oDigitSel}, 32'h1);
    check({name, "_bcd"}, {28'h0, oBCD}, 32'h0);
  endtask

  // Asserts reset between edges, checks the asynchronous effect, releases on a falling edge.
  task automatic mid_cycle_reset(input string name);
    iLoad = 1'b0; iEn = 1'b0; iUp = 1'b0;
    #2;
    iRst = 1'b1;
    #1;
    check_reset_vals(name);
    @(negedge iClk);
    iRst = 1'b0;
    edges = 0;
  endtask

  task automatic add(input logic ld, input logic [15:0] lv, input logic en, input logic up,
                     input logic [15:0] ec, input logic ecy);
    vec_t v;
    v.load = ld; v.load_val = lv; v.en = en; v.up = up;
    v.exp_count = ec; v.exp_carry = ecy;
    vecs.push_back(v);
  endtask

  logic [3:0] dig_tab [4];

  initial begin
    dig_tab = '{4'h1, 4'h2, 4'h3, 4'h4};

    add(1, 16'h0009, 0, 0, 16'h0009, 0);
    add(0, 16'h0000, 1, 1, 16'h0010, 0);
    add(1, 16'h9999, 0, 0, 16'h9999, 0);
    add(0, 16'h0000, 1, 1, 16'h0000, 1);
    add(0, 16'h0000, 1, 1, 16'h0001, 0);
    add(1, 16'h0000, 0, 0, 16'h0000, 0);
    add(0, 16'h0000, 1, 0, 16'h9999, 1);
    add(0, 16'h0000, 1, 0, 16'h9998, 0);
    add(1, 16'h1A3F, 1, 1, 16'h1030, 0);
    add(0, 16'h0000, 0, 1, 16'h1030, 0);
    add(0, 16'h0000, 1, 0, 16'h1029, 0);
    add(1, 16'h0999, 0, 0, 16'h0999, 0);
    add(0, 16'h0000, 1, 1, 16'h1000, 0);
    add(0, 16'h0000, 1, 0, 16'h0999, 0);
    add(1, 16'hF9F9, 0, 0, 16'h0909, 0);
    add(1, 16'h9999, 0, 0, 16'h9999, 0);
    add(0, 16'h0000, 1, 1, 16'h0000, 1);
    add(0, 16'h0000, 1, 0, 16'h9999, 1);
    add(0, 16'h0000, 1, 0, 16'h9998, 0);
    add(1, 16'h9999, 0, 0, 16'h9999, 0);
    add(1, 16'h9999, 1, 1, 16'h9999, 0);
    add(0, 16'h0000, 0, 0, 16'h9999, 0);

    // Power-on reset, released between edges.
    #12;
    check_reset_vals("por");
    #1;
    iRst = 1'b0;
    edges = 0;

    // Scanner on an idle count: one digit per SD edges, full frame in 4*SD.
    for (int n = 1; n <= 4 * SD; n++) begin
      step();
      check_scan("idle_scan", 16'h0000);
      if (n == SD)     check("sel_after_div", {28'h0, oDigitSel}, 32'h2);
      if (n == 4 * SD) check("sel_after_frame", {28'h0, oDigitSel}, 32'h1);
    end
    check("idle_count", {16'h0, oCount}, 32'h0);

    // Table-driven count/load vectors, one cycle each.
    foreach (vecs[i]) begin
      iLoad = vecs[i].load;
      iLoadVal = vecs[i].load_val;
      iEn = vecs[i].en;
      iUp = vecs[i].up;
      step();
      check($sformatf("vec%0d_count", i), {16'h0, oCount}, {16'h0, vecs[i].exp_count});
      check($sformatf("vec%0d_carry", i), {31'h0, oCarry}, {31'h0, vecs[i].exp_carry});
      check_scan($sformatf("vec%0d", i), vecs[i].exp_count);
    end
    iLoad = 1'b0; iEn = 1'b0;

    // Reset while the carry pulse is high clears it without an edge.
    iLoad = 1'b1; iLoadVal = 16'h9999;
    step();
    iLoad = 1'b0; iEn = 1'b1; iUp = 1'b1;
    step();
    check("wrap_pulse_carry", {31'h0, oCarry}, 32'h1);
    check("wrap_pulse_count", {16'h0, oCount}, 32'h0);
    mid_cycle_reset("carry_rst");

    // Load 4321 and hold: digits scan out 1,2,3,4 aligned with the select.
    iLoad = 1'b1; iLoadVal = 16'h4321;
    step();
    iLoad = 1'b0;
    check("load4321_count", {16'h0, oCount}, 32'h4321);
    for (int n = 0; n < 4 * SD; n++) begin
      step();
      check("frame_bcd", {28'h0, oBCD}, {28'h0, dig_tab[(edges / SD) % 4]});
      check_scan("frame", 16'h4321);
    end
    repeat (6) step();
    check("pre_rst_sel", {28'h0, oDigitSel}, 32'h2);
    mid_cycle_reset("mid_frame_rst");

    // Restart from index 0 after release.
    step();
    check_scan("restart", 16'h0000);
    check("restart_count", {16'h0, oCount}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
